// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states, opcodes,
// ALUOp values and datapath mux selects.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;

  localparam logic ADR_PC  = 1'b0;
  localparam logic ADR_ALU = 1'b1;

  // Unsupported opcodes map to S_FETCH, which doubles as the illegal marker.
  function automatic state_e decode_target(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEM_ADR;
      OP_RTYPE:          return S_EXEC_R;
      OP_ITYPE:          return S_EXEC_I;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      default:           return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style main control FSM for a multicycle RV32 datapath; outputs are a
// decode of the current state, qualified by the memory handshake and zero flag.
module multicycle_control
  import rv_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       reg_write_o,
  output logic       adr_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_o,
  output logic       retire_o
);

  state_e     state_q;
  logic [6:0] opcode_q;
  logic       pc_write;
  logic       ir_write;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready_i) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= opcode_i;
          state_q  <= decode_target(opcode_i);
        end
        // The IR may already be refetching, so use the opcode captured in DECODE.
        S_MEM_ADR: state_q <= (opcode_q == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:  if (mem_ready_i) state_q <= S_MEM_WB;
        S_MEM_WR:  if (mem_ready_i) state_q <= S_FETCH;
        S_EXEC_R,
        S_EXEC_I:  state_q <= S_ALU_WB;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    reg_write_o  = 1'b0;
    adr_src_o    = ADR_PC;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    result_src_o = 2'b00;
    alu_op_o     = 2'b00;
    illegal_o    = 1'b0;
    retire_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_a_o = SRCA_PC;
        alu_src_b_o = SRCB_FOUR;
        alu_op_o    = ALU_ADD;
        pc_write    = mem_ready_i;
        ir_write    = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLD_PC;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_ADD;
        illegal_o   = (decode_target(opcode_i) == S_FETCH);
      end
      S_MEM_ADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        adr_src_o = ADR_ALU;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_MEM;
        retire_o     = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        adr_src_o = ADR_ALU;
        retire_o  = mem_ready_i;
      end
      S_EXEC_R: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_RS2;
        alu_op_o    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_ALU_OUT;
        retire_o     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o  = SRCA_RS1;
        alu_src_b_o  = SRCB_RS2;
        alu_op_o     = ALU_SUB;
        result_src_o = RES_ALU_OUT;
        pc_write     = zero_i;
        retire_o     = 1'b1;
      end
      S_JAL: begin
        pc_write     = 1'b1;
        reg_write_o  = 1'b1;
        result_src_o = RES_ALU_OUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_FOUR;
        alu_op_o     = ALU_ADD;
        retire_o     = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural writes are suppressed while reset is held, even though the
  // FETCH request itself stays visible.
  assign pc_write_o = pc_write & rst_ni;
  assign ir_write_o = ir_write & rst_ni;

endmodule
